// File: rtl/mc_ctrl_if.sv
// Datapath <-> control unit interface for the multicycle RV32I core.
// master: the control unit (consumes op/f3/f7/zero, drives enables/selects).
// slave : the datapath (drives op/f3/f7/zero, consumes enables/selects).
interface mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             f7;
    logic             zero;
    logic             pcWrite;
    logic             adrSrc;
    logic             memWrite;
    logic             irWrite;
    logic [1:0]       resultSrc;
    logic [2:0]       ALUControl;
    logic [1:0]       aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       inmSrc;
    logic             regWrite;
    logic             illegal;
    logic             instrDone;
    logic [CNT_W-1:0] instrCount;

    modport master (
        input  op, f3, f7, zero,
        output pcWrite, adrSrc, memWrite, irWrite, resultSrc, ALUControl,
               aluSrcA, aluSrcB, inmSrc, regWrite, illegal, instrDone, instrCount
    );

    modport slave (
        output op, f3, f7, zero,
        input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, ALUControl,
               aluSrcA, aluSrcB, inmSrc, regWrite, illegal, instrDone, instrCount
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing lw/sw/R/I/beq/bne/jal,
// with illegal-opcode flag and retired-instruction counter.
// Ports: clk, rst_n (async active-low), bus (mc_ctrl_if.master: op/f3/f7/zero in,
// all datapath enables/selects, illegal, instrDone, instrCount out).
module mc_control_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.master  bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_JAL      = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    logic [3:0]       state_q, state_d;
    logic [1:0]       alu_op;
    logic             pc_update, branch, taken;
    logic             adr_src, mem_write, ir_write, reg_write, illegal_s, done_s;
    logic [1:0]       result_src, src_a, src_b, inm_src;
    logic [2:0]       alu_ctrl;
    logic [CNT_W-1:0] count_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and Moore outputs
    always_comb begin
        state_d    = S_FETCH;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        illegal_s  = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here speculatively into ALUOut
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR:        state_d = S_BRANCH;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                        done_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                done_s     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                done_s    = 1'b1;
            end
            S_EXECR: begin
                src_a   = 2'b10;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                done_s    = 1'b1;
            end
            S_BRANCH: begin
                src_a  = 2'b10;
                alu_op = ALUOP_SUB;
                branch = 1'b1;
                done_s = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU decoder; sub only for R-type (op[5]) with funct7 bit 5 set
    always_comb begin
        alu_ctrl = 3'b000;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = 3'b001;
            ALUOP_FUNCT: begin
                case (bus.f3)
                    3'b000:  alu_ctrl = (bus.op[5] & bus.f7) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl = 3'b101;
                    3'b100:  alu_ctrl = 3'b100;
                    3'b110:  alu_ctrl = 3'b011;
                    3'b111:  alu_ctrl = 3'b010;
                    default: alu_ctrl = 3'b000;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

    // Branch condition: beq / bne only
    always_comb begin
        taken = 1'b0;
        case (bus.f3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            default: taken = 1'b0;
        endcase
    end

    // Immediate format straight from the opcode
    always_comb begin
        inm_src = 2'b00;
        case (bus.op)
            OP_SW:   inm_src = 2'b01;
            OP_BR:   inm_src = 2'b10;
            OP_JAL:  inm_src = 2'b11;
            default: inm_src = 2'b00;
        endcase
    end

    // Retired-instruction counter; illegal opcodes do not retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  count_q <= '0;
        else if (done_s && !illegal_s) count_q <= count_q + CNT_W'(1);
    end

    // Enables are gated by rst_n so they drop as soon as reset asserts
    assign bus.pcWrite    = rst_n & (pc_update | (branch & taken));
    assign bus.irWrite    = rst_n & ir_write;
    assign bus.regWrite   = rst_n & reg_write;
    assign bus.memWrite   = rst_n & mem_write;
    assign bus.illegal    = rst_n & illegal_s;
    assign bus.instrDone  = rst_n & done_s;
    assign bus.adrSrc     = adr_src;
    assign bus.resultSrc  = result_src;
    assign bus.ALUControl = alu_ctrl;
    assign bus.aluSrcA    = src_a;
    assign bus.aluSrcB    = src_b;
    assign bus.inmSrc     = inm_src;
    assign bus.instrCount = count_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-cycle expected output vectors are
// queued when an instruction is applied and popped at each falling edge.
module tb_mc_control_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) bus ();
    mc_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.op   = bus.op;
    assign bus4.f3   = bus.f3;
    assign bus4.f7   = bus.f7;
    assign bus4.zero = bus.zero;

    mc_control_unit #(.CNT_W(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mc_control_unit #(.CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    localparam int P_F = 0, P_D = 1, P_DI = 2, P_MA = 3, P_MR = 4, P_MWB = 5,
                   P_MW = 6, P_ER = 7, P_EI = 8, P_JAL = 9, P_AWB = 10, P_BR = 11;

    typedef struct {
        logic [17:0] v;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = 0;
    logic [3:0]  exp_small = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] obs();
        return {bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite, bus.resultSrc,
                bus.ALUControl, bus.aluSrcA, bus.aluSrcB, bus.inmSrc,
                bus.regWrite, bus.illegal, bus.instrDone};
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
               (op == 7'b0010011) || (op == 7'b1100011) || (op == 7'b1101111);
    endfunction

    // Expected outputs for one phase, written from the state output table
    function automatic logic [17:0] exp_out(input int p, input logic [6:0] op,
                                            input logic [2:0] f3, input logic f7,
                                            input logic zero);
        logic       pcw, adr, mw, irw, rw, ill, dn;
        logic [1:0] res, a, b, inm;
        logic [2:0] alu, funct;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; dn = 0;
        res = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        case (op)
            7'b0100011: inm = 2'b01;
            7'b1100011: inm = 2'b10;
            7'b1101111: inm = 2'b11;
            default:    inm = 2'b00;
        endcase
        case (f3)
            3'b000:  funct = (op[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  funct = 3'b101;
            3'b100:  funct = 3'b100;
            3'b110:  funct = 3'b011;
            3'b111:  funct = 3'b010;
            default: funct = 3'b000;
        endcase
        case (p)
            P_F:   begin irw = 1; pcw = 1; b = 2'b10; res = 2'b10; end
            P_D:   begin a = 2'b01; b = 2'b01; end
            P_DI:  begin a = 2'b01; b = 2'b01; ill = 1; dn = 1; end
            P_MA:  begin a = 2'b10; b = 2'b01; end
            P_MR:  begin adr = 1; end
            P_MWB: begin res = 2'b01; rw = 1; dn = 1; end
            P_MW:  begin adr = 1; mw = 1; dn = 1; end
            P_ER:  begin a = 2'b10; alu = funct; end
            P_EI:  begin a = 2'b10; b = 2'b01; alu = funct; end
            P_JAL: begin a = 2'b01; b = 2'b10; pcw = 1; end
            P_AWB: begin rw = 1; dn = 1; end
            P_BR:  begin
                a = 2'b10; alu = 3'b001; dn = 1;
                pcw = (f3 == 3'b000) ? zero : (f3 == 3'b001) ? ~zero : 1'b0;
            end
            default: ;
        endcase
        return {pcw, adr, mw, irw, res, alu, a, b, inm, rw, ill, dn};
    endfunction

    // Apply one instruction starting in FETCH; checks every cycle and the count after
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic zero);
        int   ph[$];
        exp_t e;
        ph = '{P_F};
        case (op)
            7'b0000011: ph = '{P_F, P_D, P_MA, P_MR, P_MWB};
            7'b0100011: ph = '{P_F, P_D, P_MA, P_MW};
            7'b0110011: ph = '{P_F, P_D, P_ER, P_AWB};
            7'b0010011: ph = '{P_F, P_D, P_EI, P_AWB};
            7'b1101111: ph = '{P_F, P_D, P_JAL, P_AWB};
            7'b1100011: ph = '{P_F, P_D, P_BR};
            default:    ph = '{P_F, P_DI};
        endcase
        bus.op = op; bus.f3 = f3; bus.f7 = f7; bus.zero = zero;
        foreach (ph[i]) begin
            e.v   = exp_out(ph[i], op, f3, f7, zero);
            e.tag = $sformatf("%s/c%0d", name, i + 1);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            check(e.tag, 32'(obs()), 32'(e.v));
        end
        @(posedge clk);
        #1;
        if (is_legal(op)) begin
            exp_count = exp_count + 1;
            exp_small = exp_small + 4'd1;
        end
        check({name, "/count"}, bus.instrCount, exp_count);
        check({name, "/count4"}, 32'(bus4.instrCount), 32'(exp_small));
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.op  = 7'd0; bus.f3 = 3'd0; bus.f7 = 1'b0; bus.zero = 1'b0;
        #1;
        check("rst/outs", 32'(obs()), 32'(18'b0_0_0_0_10_000_00_10_00_0_0_0));
        check("rst/count", bus.instrCount, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0);
        run_instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0);
        run_instr("add",     7'b0110011, 3'b000, 1'b0, 1'b0);
        run_instr("addi",    7'b0010011, 3'b000, 1'b1, 1'b0);
        run_instr("and",     7'b0110011, 3'b111, 1'b0, 1'b0);
        run_instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b0);
        run_instr("xori",    7'b0010011, 3'b100, 1'b0, 1'b0);
        run_instr("or",      7'b0110011, 3'b110, 1'b0, 1'b0);
        run_instr("sll",     7'b0110011, 3'b001, 1'b0, 1'b0);
        run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0);
        run_instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1);
        run_instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0);
        run_instr("bne_t",   7'b1100011, 3'b001, 1'b0, 1'b0);
        run_instr("bne_nt",  7'b1100011, 3'b001, 1'b0, 1'b1);
        run_instr("blt_nt",  7'b1100011, 3'b100, 1'b0, 1'b1);
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);

        // Reset asserted during the MEMWRITE cycle of a store
        bus.op = 7'b0100011; bus.f3 = 3'b010; bus.f7 = 1'b0; bus.zero = 1'b0;
        @(negedge clk); check("sw_rst/c1", 32'(obs()), 32'(exp_out(P_F,  bus.op, 3'b010, 1'b0, 1'b0)));
        @(negedge clk); check("sw_rst/c2", 32'(obs()), 32'(exp_out(P_D,  bus.op, 3'b010, 1'b0, 1'b0)));
        @(negedge clk); check("sw_rst/c3", 32'(obs()), 32'(exp_out(P_MA, bus.op, 3'b010, 1'b0, 1'b0)));
        @(negedge clk); check("sw_rst/c4", 32'(obs()), 32'(exp_out(P_MW, bus.op, 3'b010, 1'b0, 1'b0)));
        #2 rst_n = 1'b0;
        #1;
        check("sw_rst/memWrite", 32'(bus.memWrite), 32'd0);
        check("sw_rst/outs", 32'(obs()), 32'(18'b0_0_0_0_10_000_00_10_01_0_0_0));
        @(posedge clk);
        #1;
        check("sw_rst/count", bus.instrCount, 32'd0);
        check("sw_rst/count4", 32'(bus4.instrCount), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_count = 0;
        exp_small = 4'd0;

        // First instruction after release must start from FETCH
        run_instr("lw_post", 7'b0000011, 3'b010, 1'b0, 1'b0);

        // Drive the 4-bit counter up to 15, then one more wraps it to 0
        for (int i = 0; i < 14; i++)
            run_instr($sformatf("fill%0d", i), 7'b1100011, 3'b000, 1'b0, 1'b0);
        check("wrap/pre", 32'(bus4.instrCount), 32'd15);
        run_instr("wrap", 7'b0010011, 3'b000, 1'b0, 1'b0);
        check("wrap/zero", 32'(bus4.instrCount), 32'd0);
        check("wrap/main", bus.instrCount, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
